// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - ADC sampling sequencer with DRP result readout
//
// Purpose:
//   Generates a periodic sample tick. On each tick it converts NUM_CH
//   channels in order. For each channel it pulses convst, waits for eoc,
//   reads the result over a DRP read handshake, and emits one
//   adc_data/adc_data_valid beat tagged with the channel index.
//   Ticks that arrive mid-sequence are dropped and flagged as overruns.
//   Stalled eoc/drdy waits are flagged as timeouts.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   enable              run the tick generator and the sequencer
//   sample_div          tick period minus 1, in aclk cycles
//   err_clr             clears overrun and timeout_err (a set event wins)
//   convst / eoc        conversion start pulse / end of conversion
//   drp_den, drp_dwe    DRP read enable pulse; write enable (always 0)
//   drp_daddr           DRP address, CH_ADDR_BASE + channel
//   drp_drdy, drp_do    DRP data ready and read data
//   adc_data, adc_ch    captured sample and its channel index
//   adc_data_valid      one-cycle strobe for adc_data/adc_ch
//   overrun             sticky: tick arrived while the FSM was busy
//   timeout_err         sticky: eoc or drdy wait ran out
//   busy                FSM not in IDLE
module adc_seq_ctrl #(
  parameter int unsigned NUM_CH       = 2,
  parameter logic [6:0]  CH_ADDR_BASE = 7'h10,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             enable,
  input  logic [DIV_W-1:0] sample_div,
  input  logic             err_clr,
  output logic             convst,
  input  logic             eoc,
  output logic             drp_den,
  output logic             drp_dwe,
  output logic [6:0]       drp_daddr,
  input  logic             drp_drdy,
  input  logic [15:0]      drp_do,
  output logic [15:0]      adc_data,
  output logic             adc_data_valid,
  output logic [3:0]       adc_ch,
  output logic             overrun,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT + 1);
  // The wait counter is 0 in the first cycle of a state, so this value
  // marks the last allowed cycle: the flag then shows TIMEOUT cycles
  // after entry.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [3:0]        CH_LAST   = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    READ,
    OUT
  } state_t;

  // Tick generator
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick;

  always_comb begin
    tick = enable && (cnt_q == '0);
    if (!enable || tick) begin
      cnt_d = sample_div;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Sequencer state and registered outputs
  state_t            state_q, state_d;
  logic [3:0]        ch_q, ch_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              convst_q, convst_d;
  logic              den_q, den_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [15:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic [3:0]        adc_ch_q, adc_ch_d;
  logic              ovr_q, ovr_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;
  logic              to_set;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    wcnt_d   = wcnt_q + WAIT_W'(1);
    convst_d = 1'b0;
    den_d    = 1'b0;
    daddr_d  = daddr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    adc_ch_d = adc_ch_q;
    to_set   = 1'b0;

    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (tick) begin
          state_d  = CONV;
          ch_d     = 4'd0;
          convst_d = 1'b1;
        end
      end
      CONV: begin
        // convst_q is high only in the entry cycle; eoc is not accepted there.
        if (eoc && !convst_q) begin
          state_d = READ;
          wcnt_d  = '0;
          den_d   = 1'b1;
          daddr_d = CH_ADDR_BASE + {3'b000, ch_q};
        end else if (wcnt_q == WAIT_LAST) begin
          to_set  = 1'b1;
          state_d = IDLE;
          ch_d    = 4'd0;
          wcnt_d  = '0;
        end
      end
      READ: begin
        if (drp_drdy) begin
          state_d  = OUT;
          wcnt_d   = '0;
          data_d   = drp_do;
          adc_ch_d = ch_q;
          valid_d  = 1'b1;
        end else if (wcnt_q == WAIT_LAST) begin
          to_set  = 1'b1;
          state_d = IDLE;
          ch_d    = 4'd0;
          wcnt_d  = '0;
        end
      end
      OUT: begin
        wcnt_d = '0;
        if (ch_q == CH_LAST || !enable) begin
          state_d = IDLE;
          ch_d    = 4'd0;
        end else begin
          state_d  = CONV;
          ch_d     = ch_q + 4'd1;
          convst_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = 4'd0;
        wcnt_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);

    // Set has priority over clear on both sticky flags.
    if (tick && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (err_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (to_set) begin
      to_d = 1'b1;
    end else if (err_clr) begin
      to_d = 1'b0;
    end else begin
      to_d = to_q;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q    <= '0;
      state_q  <= IDLE;
      ch_q     <= 4'd0;
      wcnt_q   <= '0;
      convst_q <= 1'b0;
      den_q    <= 1'b0;
      daddr_q  <= CH_ADDR_BASE;
      data_q   <= 16'h0000;
      valid_q  <= 1'b0;
      adc_ch_q <= 4'd0;
      ovr_q    <= 1'b0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ch_q     <= ch_d;
      wcnt_q   <= wcnt_d;
      convst_q <= convst_d;
      den_q    <= den_d;
      daddr_q  <= daddr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      adc_ch_q <= adc_ch_d;
      ovr_q    <= ovr_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
    end
  end

  assign convst         = convst_q;
  assign drp_den        = den_q;
  assign drp_dwe        = 1'b0;
  assign drp_daddr      = daddr_q;
  assign adc_data       = data_q;
  assign adc_data_valid = valid_q;
  assign adc_ch         = adc_ch_q;
  assign overrun        = ovr_q;
  assign timeout_err    = to_q;
  assign busy           = busy_q;

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
- Sampling sequencer for the on-chip ADC; sits upstream of the ADC capture register bank.
- Generates a periodic sample tick and, on each tick, converts NUM_CH channels in order.
- Per channel: pulses convst, waits for eoc, reads the result over a DRP-style read handshake, then emits one adc_data/adc_data_valid beat tagged with the channel index.
- Flags overruns (tick while busy) and handshake timeouts.

Parameters:
- NUM_CH, 2: channels per sequence, 1..16.
- CH_ADDR_BASE, 7'h10: DRP address of channel 0; channel k is read at CH_ADDR_BASE+k.
- DIV_W, 16: width of sample_div.
- TIMEOUT, 1023: maximum cycles to wait for eoc or drp_drdy.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- enable  in  1  run sequencer
- sample_div  in  DIV_W  tick period minus 1, in aclk cycles
- err_clr  in  1  clears the sticky flags
- convst  out  1  conversion start pulse
- eoc  in  1  end of conversion
- drp_den  out  1  DRP read enable pulse
- drp_dwe  out  1  tied 0
- drp_daddr  out  7  DRP address
- drp_drdy  in  1  DRP data ready
- drp_do  in  16  DRP read data
- adc_data  out  16  sample value
- adc_data_valid  out  1  one-cycle data strobe
- adc_ch  out  4  channel index of adc_data
- overrun  out  1  sticky: tick arrived while not IDLE
- timeout_err  out  1  sticky: eoc or drdy wait exceeded TIMEOUT
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; ch = 0; tick counter = 0.
  - All outputs 0; adc_data = 0; drp_daddr = CH_ADDR_BASE.
- All outputs are registered.
- Tick counter:
  - While enable = 0: counter loaded with sample_div, no ticks.
  - While enable = 1: decrements; at 0 it generates tick and reloads sample_div. Period = sample_div+1 cycles.
  - A new sample_div value takes effect at the next reload.
- FSM states: IDLE, CONV, READ, OUT.
  - IDLE: on tick (with enable = 1) -> CONV; ch = 0.
  - CONV:
    - convst = 1 for exactly the first cycle in the state.
    - eoc = 1 while not in that first cycle -> READ.
    - Wait counter reaches TIMEOUT -> timeout_err = 1, ch = 0, -> IDLE.
  - READ:
    - drp_den = 1 for exactly the first cycle; drp_daddr = CH_ADDR_BASE+ch, held through the state.
    - drp_drdy = 1 -> capture drp_do into adc_data, adc_ch = ch, -> OUT.
    - Timeout handling is the same as in CONV.
  - OUT:
    - adc_data_valid = 1 for this single cycle.
    - If ch = NUM_CH-1 or enable = 0: ch = 0, -> IDLE.
    - Otherwise: ch+1, -> CONV.
  - The wait counter clears on every state entry.
- Latency: tick -> convst 1 cycle; eoc -> drp_den 1 cycle; drdy -> adc_data_valid 1 cycle.
- Tick while FSM not IDLE:
  - The tick is dropped; overrun = 1.
  - The sequence in progress continues unaffected.
- enable deasserted mid-sequence: the current channel completes through OUT, then IDLE; no further channels start.
- eoc or drdy arriving outside the waiting state: ignored.
- err_clr = 1 clears overrun and timeout_err. If a set event occurs in the same cycle, set wins.
- busy = (state != IDLE).
- drp_dwe is constant 0.

Test Plan:
- Basic sequence: NUM_CH=2, sample_div=99, enable=1; eoc 5 cycles after convst; drdy 2 cycles after den with drp_do=16'h0ABC then 16'h0123.
  - Required: two valid beats, (ch0, 0ABC) then (ch1, 0123).
  - Required: drp_daddr 7'h10 then 7'h11.
  - Required: next sequence's convst exactly 100 cycles after the first convst.
- Overrun: sample_div=3; eoc delayed 20 cycles.
  - Required: overrun=1 and the sequence still completes.
  - Required: err_clr pulse -> overrun=0 next cycle.
- Timeout: eoc never asserted.
  - Required: timeout_err=1 exactly TIMEOUT cycles after CONV entry; FSM returns to IDLE; no adc_data_valid.
  - Required: the next tick restarts at ch0.
- Enable drop: deassert enable during the ch0 READ.
  - Required: the ch0 beat is emitted; no convst for ch1; no further ticks.
- Async reset: assert areset during READ, not aligned to an aclk edge.
  - Required: all outputs 0 immediately; after release and the first tick, the sequence restarts at ch0.
- Boundary: sample_div=0 with instant eoc/drdy (asserted 1 cycle after their strobes).
  - Required: a tick every cycle and overrun set.
  - Required: back-to-back channels ch0..NUM_CH-1 with no gaps beyond state latency.
